// File: rtl/dino_game_controller.sv
// dino_game_controller: scroll-step timing, jump, collision and saturating score
// sequencer for the dino runner, sitting between the debouncers and the generator.
module dino_game_controller #(
   parameter logic [23:0] TICK_INIT     = 24'd12_500_000,
   parameter logic [23:0] TICK_MIN      = 24'd3_000_000,
   parameter logic [23:0] TICK_STEP     = 24'd500_000,
   parameter logic [7:0]  SPEEDUP_EVERY = 8'd5,
   parameter logic [3:0]  JUMP_STEPS    = 4'd3,
   parameter int          DINO_POS      = 3,
   parameter int          SCORE_W       = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start_btn,
   input  logic               jump_btn,
   input  logic [7:0]         led_line,
   output logic               step,
   output logic               gen_reset,
   output logic               dino_up,
   output logic [SCORE_W-1:0] score,
   output logic               game_over,
   output logic               playing
);

   typedef enum logic [1:0] {IDLE, CLEAR, RUN, OVER} state_t;

   state_t             state_q, state_d;
   logic               start_q, jump_q, check_q;
   logic [23:0]        div_q, div_d, per_q, per_d;
   logic [3:0]         jcnt_q, jcnt_d, clr_q, clr_d;
   logic [7:0]         spd_q, spd_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic               up_q, up_d, up_mid;
   logic               start_e, jump_e, counting, hit;
   logic               unused_led;

   assign start_e    = start_btn & ~start_q;
   assign jump_e     = jump_btn & ~jump_q;
   assign counting   = state_q == CLEAR || state_q == RUN;
   assign step       = counting && div_q == per_q - 24'd1;
   assign hit        = led_line[DINO_POS];
   assign unused_led = ^led_line;
   assign gen_reset  = state_q != RUN;
   assign playing    = state_q == RUN;
   assign game_over  = state_q == OVER;
   assign score      = score_q;
   assign dino_up    = up_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         jump_q  <= 1'b0;
         check_q <= 1'b0;
         div_q   <= '0;
         per_q   <= TICK_INIT;
         jcnt_q  <= '0;
         clr_q   <= '0;
         spd_q   <= '0;
         score_q <= '0;
         up_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start_btn;
         jump_q  <= jump_btn;
         check_q <= step;
         div_q   <= div_d;
         per_q   <= per_d;
         jcnt_q  <= jcnt_d;
         clr_q   <= clr_d;
         spd_q   <= spd_d;
         score_q <= score_d;
         up_q    <= up_d;
      end
   end

   always_comb begin
      state_d = state_q;
      div_d   = step ? '0 : div_q + 24'd1;
      per_d   = per_q;
      jcnt_d  = jcnt_q;
      clr_d   = clr_q;
      spd_d   = spd_q;
      score_d = score_q;
      up_mid  = up_q;
      up_d    = up_q;
      unique case (state_q)
         IDLE, OVER: begin
            if (start_e) begin
               state_d = CLEAR;
               per_d   = TICK_INIT;
               score_d = '0;
               up_mid  = 1'b0;
               up_d    = 1'b0;
               jcnt_d  = '0;
               clr_d   = '0;
               spd_d   = '0;
            end
         end
         CLEAR: begin
            // nine checks flush the eight LEDs plus the generator output register
            if (check_q) begin
               clr_d   = clr_q + 4'd1;
               state_d = clr_q == 4'd8 ? RUN : CLEAR;
            end
         end
         RUN: begin
            if (check_q && hit && !up_q) begin
               state_d = OVER;
            end else if (check_q) begin
               if (hit && score_q != '1) begin
                  score_d = score_q + SCORE_W'(1);
                  spd_d   = spd_q == SPEEDUP_EVERY - 8'd1 ? 8'd0 : spd_q + 8'd1;
                  if (spd_q == SPEEDUP_EVERY - 8'd1)
                     per_d = {1'b0, per_q} >= {1'b0, TICK_MIN} + {1'b0, TICK_STEP} ? per_q - TICK_STEP : TICK_MIN;
               end
               if (up_q) begin
                  jcnt_d = jcnt_q - 4'd1;
                  up_mid = jcnt_q != 4'd1;
               end
            end
            up_d = up_mid;
            // a jump landing on a check cycle sees the post-evaluation airborne state
            if (state_d == RUN && jump_e && !up_mid) begin
               up_d   = 1'b1;
               jcnt_d = JUMP_STEPS;
            end
         end
      endcase
      if (!(state_d == CLEAR || state_d == RUN) || !counting)
         div_d = '0;
   end

endmodule
